banco_registradores_multiporta: RTL and testbench

- Parametrised successor to the processor's single-write register bank: NUM_REGS x DATA_W storage, two combinational read ports, one debug read port and two write ports.
- Write port A carries ALU writeback; write port B carries load/memory writeback.
- Adds an async active-low clear and a per-register pending-load scoreboard, so the pipeline control can detect RAW hazards on outstanding loads.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes).

---
 rtl/banco_registradores_multiporta_pkg.sv | 20 ++
 rtl/banco_registradores_multiporta_placa_pendencias.sv | 41 ++++
 rtl/banco_registradores_multiporta.sv | 124 ++++++++++++
 tb/tb_banco_registradores_multiporta.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_multiporta_pkg.sv
// banco_pkg: shared definitions for the multi-port register bank.
//   DEFAULT_DATA_W / DEFAULT_NUM_REGS : default geometry
//   palavra_t                         : register word at the default width
//   REG_ZERO                          : address of the hardwired-zero register
//   prio_t                            : write-port priority on address collision
package banco_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  typedef logic [DEFAULT_DATA_W-1:0] palavra_t;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage

// File: rtl/banco_registradores_multiporta_placa_pendencias.sv
// placa_pendencias: one pending bit per register, tracking outstanding loads.
//   clock, reset_n          : rising-edge clock, async active-low clear
//   marca / end_marca       : set the bit of end_marca (load issued)
//   limpa / end_limpa       : clear the bit of end_limpa (load written back)
//   end_cons_1 / end_cons_2 : lookup addresses
//   pend_1 / pend_2         : current (registered) bits at the lookup addresses
module placa_pendencias #(
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              marca,
  input  logic [ADDR_W-1:0] end_marca,
  input  logic              limpa,
  input  logic [ADDR_W-1:0] end_limpa,
  input  logic [ADDR_W-1:0] end_cons_1,
  input  logic [ADDR_W-1:0] end_cons_2,
  output logic              pend_1,
  output logic              pend_2
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_next;

  // Set is applied after clear so a new load to the same register wins.
  always_comb begin
    pend_next = pend;
    if (limpa) pend_next[end_limpa] = 1'b0;
    if (marca) pend_next[end_marca] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pend <= '0;
    else          pend <= pend_next;
  end

  assign pend_1 = pend[end_cons_1];
  assign pend_2 = pend[end_cons_2];

endmodule

// File: rtl/banco_registradores_multiporta.sv
// banco_registradores_multiporta: NUM_REGS x DATA_W register bank with two
// write ports (A = ALU writeback, B = load writeback), two read ports, one
// debug read port and a pending-load scoreboard for RAW hazard detection.
//   clock, reset_n             : rising-edge clock, async active-low clear
//   wren_a/end_reg_a/data_a    : write port A
//   wren_b/end_reg_b/data_b    : write port B, also clears the pending bit
//   reserva/end_reg_r          : mark a register pending
//   end_reg_1/2, reg_1/2_out   : combinational read ports
//   end_reg_dbg, reg_dbg_out   : debug read of the raw array (never bypassed)
//   pendente_1/2               : pending bit of the read addresses
//   conflito                   : registered same-address A/B write collision
// Optional: define BANCO_BYPASS_EN to forward same-cycle writes to the read
// ports and same-cycle port-B clears to pendente_1/2.
module banco_registradores_multiporta
  import banco_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wren_a,
  input  logic [ADDR_W-1:0] end_reg_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_b,
  input  logic [ADDR_W-1:0] end_reg_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              reserva,
  input  logic [ADDR_W-1:0] end_reg_r,
  input  logic [ADDR_W-1:0] end_reg_1,
  input  logic [ADDR_W-1:0] end_reg_2,
  input  logic [ADDR_W-1:0] end_reg_dbg,
  output logic [DATA_W-1:0] reg_1_out,
  output logic [DATA_W-1:0] reg_2_out,
  output logic [DATA_W-1:0] reg_dbg_out,
  output logic              pendente_1,
  output logic              pendente_2,
  output logic              conflito
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(REG_ZERO);
  localparam prio_t             WRITE_PRIO = PRIO_B;
  localparam logic              ZR         = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic we_a, we_b, res_en;
  logic [DATA_W-1:0] rd1_raw, rd2_raw;
  logic pend_1_raw, pend_2_raw;

  // Accesses to register 0 are dropped here when it is hardwired to zero.
  assign we_a   = wren_a  && !(ZR && (end_reg_a == ADDR_ZERO));
  assign we_b   = wren_b  && !(ZR && (end_reg_b == ADDR_ZERO));
  assign res_en = reserva && !(ZR && (end_reg_r == ADDR_ZERO));

  // Collision arbitration: the later nonblocking write to an address wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      conflito <= 1'b0;
    end else begin
      if (WRITE_PRIO == PRIO_B) begin
        if (we_a) mem[end_reg_a] <= data_a;
        if (we_b) mem[end_reg_b] <= data_b;
      end else begin
        if (we_b) mem[end_reg_b] <= data_b;
        if (we_a) mem[end_reg_a] <= data_a;
      end
      conflito <= we_a && we_b && (end_reg_a == end_reg_b);
    end
  end

  placa_pendencias #(
    .NUM_REGS (NUM_REGS)
  ) u_placa (
    .clock      (clock),
    .reset_n    (reset_n),
    .marca      (res_en),
    .end_marca  (end_reg_r),
    .limpa      (we_b),
    .end_limpa  (end_reg_b),
    .end_cons_1 (end_reg_1),
    .end_cons_2 (end_reg_2),
    .pend_1     (pend_1_raw),
    .pend_2     (pend_2_raw)
  );

  always_comb begin
    rd1_raw = mem[end_reg_1];
    rd2_raw = mem[end_reg_2];
    if (ZR && (end_reg_1 == ADDR_ZERO)) rd1_raw = '0;
    if (ZR && (end_reg_2 == ADDR_ZERO)) rd2_raw = '0;
  end

  assign reg_dbg_out = mem[end_reg_dbg];

`ifdef BANCO_BYPASS_EN
  // Port B is checked first so load data takes priority, matching the array.
  always_comb begin
    reg_1_out  = rd1_raw;
    reg_2_out  = rd2_raw;
    pendente_1 = pend_1_raw;
    pendente_2 = pend_2_raw;
    if (reset_n) begin
      if (we_b && (end_reg_b == end_reg_1))      reg_1_out = data_b;
      else if (we_a && (end_reg_a == end_reg_1)) reg_1_out = data_a;
      if (we_b && (end_reg_b == end_reg_2))      reg_2_out = data_b;
      else if (we_a && (end_reg_a == end_reg_2)) reg_2_out = data_a;
      if (we_b && (end_reg_b == end_reg_1) && !(res_en && (end_reg_r == end_reg_1)))
        pendente_1 = 1'b0;
      if (we_b && (end_reg_b == end_reg_2) && !(res_en && (end_reg_r == end_reg_2)))
        pendente_2 = 1'b0;
    end
  end
`else
  assign reg_1_out  = rd1_raw;
  assign reg_2_out  = rd2_raw;
  assign pendente_1 = pend_1_raw;
  assign pendente_2 = pend_2_raw;
`endif

endmodule

// File: tb/tb_banco_registradores_multiporta.sv
module tb_banco_registradores_multiporta;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wren_a, wren_b, reserva;
  logic [4:0]  end_reg_a, end_reg_b, end_reg_r, end_reg_1, end_reg_2, end_reg_dbg;
  logic [31:0] data_a, data_b;

  logic [31:0] reg_1_out, reg_2_out, reg_dbg_out;
  logic        pendente_1, pendente_2, conflito;

  logic [31:0] z_reg_1_out, z_reg_2_out, z_reg_dbg_out;
  logic        z_pendente_1, z_pendente_2, z_conflito;

  logic [15:0] p_reg_1_out, p_reg_2_out, p_reg_dbg_out;
  logic        p_pendente_1, p_pendente_2, p_conflito;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  banco_registradores_multiporta dut (
    .clock(clock), .reset_n(reset_n),
    .wren_a(wren_a), .end_reg_a(end_reg_a), .data_a(data_a),
    .wren_b(wren_b), .end_reg_b(end_reg_b), .data_b(data_b),
    .reserva(reserva), .end_reg_r(end_reg_r),
    .end_reg_1(end_reg_1), .end_reg_2(end_reg_2), .end_reg_dbg(end_reg_dbg),
    .reg_1_out(reg_1_out), .reg_2_out(reg_2_out), .reg_dbg_out(reg_dbg_out),
    .pendente_1(pendente_1), .pendente_2(pendente_2), .conflito(conflito)
  );

  banco_registradores_multiporta #(.ZERO_REG(0)) dut_z (
    .clock(clock), .reset_n(reset_n),
    .wren_a(wren_a), .end_reg_a(end_reg_a), .data_a(data_a),
    .wren_b(wren_b), .end_reg_b(end_reg_b), .data_b(data_b),
    .reserva(reserva), .end_reg_r(end_reg_r),
    .end_reg_1(end_reg_1), .end_reg_2(end_reg_2), .end_reg_dbg(end_reg_dbg),
    .reg_1_out(z_reg_1_out), .reg_2_out(z_reg_2_out), .reg_dbg_out(z_reg_dbg_out),
    .pendente_1(z_pendente_1), .pendente_2(z_pendente_2), .conflito(z_conflito)
  );

  banco_registradores_multiporta #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(0)) dut_p (
    .clock(clock), .reset_n(reset_n),
    .wren_a(wren_a), .end_reg_a(end_reg_a[2:0]), .data_a(data_a[15:0]),
    .wren_b(wren_b), .end_reg_b(end_reg_b[2:0]), .data_b(data_b[15:0]),
    .reserva(reserva), .end_reg_r(end_reg_r[2:0]),
    .end_reg_1(end_reg_1[2:0]), .end_reg_2(end_reg_2[2:0]), .end_reg_dbg(end_reg_dbg[2:0]),
    .reg_1_out(p_reg_1_out), .reg_2_out(p_reg_2_out), .reg_dbg_out(p_reg_dbg_out),
    .pendente_1(p_pendente_1), .pendente_2(p_pendente_2), .conflito(p_conflito)
  );

  task automatic idle();
    wren_a  = 1'b0;
    wren_b  = 1'b0;
    reserva = 1'b0;
  endtask

  // Advance past the next rising edge, then drop all enables.
  task automatic step();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    idle();
    end_reg_a = '0; end_reg_b = '0; end_reg_r = '0;
    end_reg_1 = 5'd5; end_reg_2 = 5'd5; end_reg_dbg = 5'd5;
    data_a = '0; data_b = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (reg_1_out !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want %h", reg_1_out, 32'h0); end
    checks++; if (pendente_1 !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", pendente_1); end
    checks++; if (conflito !== 1'b0) begin errors++; $display("FAIL reset_conf got %b want 0", conflito); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    // r5 <- DEADBEEF and reserved
    wren_a = 1'b1; end_reg_a = 5'd5; data_a = 32'hDEADBEEF;
    reserva = 1'b1; end_reg_r = 5'd5;
    step();
    checks++; if (reg_1_out !== 32'hDEADBEEF) begin errors++; $display("FAIL r5_write got %h want %h", reg_1_out, 32'hDEADBEEF); end
    checks++; if (pendente_1 !== 1'b1) begin errors++; $display("FAIL r5_pend got %b want 1", pendente_1); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (reg_1_out !== 32'h0) begin errors++; $display("FAIL midreset_rd1 got %h want 0", reg_1_out); end
    checks++; if (pendente_1 !== 1'b0) begin errors++; $display("FAIL midreset_pend got %b want 0", pendente_1); end
    checks++; if (conflito !== 1'b0) begin errors++; $display("FAIL midreset_conf got %b want 0", conflito); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_dual_write();
    wren_a = 1'b1; end_reg_a = 5'd3; data_a = 32'h11;
    wren_b = 1'b1; end_reg_b = 5'd4; data_b = 32'h22;
    step();
    end_reg_1 = 5'd3; end_reg_2 = 5'd4; #1;
    checks++; if (reg_1_out !== 32'h11) begin errors++; $display("FAIL dual_r3 got %h want 11", reg_1_out); end
    checks++; if (reg_2_out !== 32'h22) begin errors++; $display("FAIL dual_r4 got %h want 22", reg_2_out); end
    checks++; if (conflito !== 1'b0) begin errors++; $display("FAIL dual_noconf got %b want 0", conflito); end
    @(posedge clock); #1;
    wren_a = 1'b1; end_reg_a = 5'd7; data_a = 32'hAA;
    wren_b = 1'b1; end_reg_b = 5'd7; data_b = 32'hBB;
    step();
    end_reg_1 = 5'd7; #1;
    checks++; if (reg_1_out !== 32'hBB) begin errors++; $display("FAIL coll_r7 got %h want bb", reg_1_out); end
    checks++; if (conflito !== 1'b1) begin errors++; $display("FAIL coll_conf got %b want 1", conflito); end
    step();
    checks++; if (conflito !== 1'b0) begin errors++; $display("FAIL coll_conf_drop got %b want 0", conflito); end
  endtask

  task automatic test_zero_reg();
    wren_a = 1'b1; end_reg_a = 5'd0; data_a = 32'hFFFFFFFF;
    reserva = 1'b1; end_reg_r = 5'd0;
    step();
    end_reg_1 = 5'd0; #1;
    checks++; if (reg_1_out !== 32'h0) begin errors++; $display("FAIL zero_rd got %h want 0", reg_1_out); end
    checks++; if (pendente_1 !== 1'b0) begin errors++; $display("FAIL zero_pend got %b want 0", pendente_1); end
    checks++; if (z_reg_1_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL plain_r0 got %h want ffffffff", z_reg_1_out); end
    checks++; if (z_pendente_1 !== 1'b1) begin errors++; $display("FAIL plain_r0_pend got %b want 1", z_pendente_1); end
    wren_a = 1'b1; end_reg_a = 5'd0; data_a = 32'h1;
    wren_b = 1'b1; end_reg_b = 5'd0; data_b = 32'h2;
    step();
    checks++; if (conflito !== 1'b0) begin errors++; $display("FAIL zero_conf got %b want 0", conflito); end
    checks++; if (z_conflito !== 1'b1) begin errors++; $display("FAIL plain_conf got %b want 1", z_conflito); end
    checks++; if (z_reg_1_out !== 32'h2) begin errors++; $display("FAIL plain_r0_coll got %h want 2", z_reg_1_out); end
  endtask

  task automatic test_scoreboard();
    end_reg_1 = 5'd9; end_reg_2 = 5'd9;
    reserva = 1'b1; end_reg_r = 5'd9; #1;
    checks++; if (pendente_1 !== 1'b0) begin errors++; $display("FAIL pend_no_fwd got %b want 0", pendente_1); end
    step();
    checks++; if (pendente_1 !== 1'b1) begin errors++; $display("FAIL pend_set got %b want 1", pendente_1); end
    checks++; if (pendente_2 !== 1'b1) begin errors++; $display("FAIL pend_set_p2 got %b want 1", pendente_2); end
    wren_a = 1'b1; end_reg_a = 5'd9; data_a = 32'h5;
    step();
    checks++; if (pendente_1 !== 1'b1) begin errors++; $display("FAIL pend_after_a got %b want 1", pendente_1); end
    checks++; if (reg_1_out !== 32'h5) begin errors++; $display("FAIL r9_a got %h want 5", reg_1_out); end
    wren_b = 1'b1; end_reg_b = 5'd9; data_b = 32'h6;
    step();
    checks++; if (pendente_1 !== 1'b0) begin errors++; $display("FAIL pend_clr got %b want 0", pendente_1); end
    checks++; if (reg_1_out !== 32'h6) begin errors++; $display("FAIL r9_b got %h want 6", reg_1_out); end
    reserva = 1'b1; end_reg_r = 5'd9;
    wren_b = 1'b1; end_reg_b = 5'd9; data_b = 32'h7;
    step();
    checks++; if (pendente_1 !== 1'b1) begin errors++; $display("FAIL pend_set_wins got %b want 1", pendente_1); end
    checks++; if (reg_1_out !== 32'h7) begin errors++; $display("FAIL r9_b2 got %h want 7", reg_1_out); end
    reserva = 1'b1; end_reg_r = 5'd9;
    step();
    checks++; if (pendente_1 !== 1'b1) begin errors++; $display("FAIL pend_rereserve got %b want 1", pendente_1); end
    wren_b = 1'b1; end_reg_b = 5'd9; data_b = 32'h8;
    step();
    checks++; if (pendente_1 !== 1'b0) begin errors++; $display("FAIL pend_no_count got %b want 0", pendente_1); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    logic        exp_pd;
    wren_a = 1'b1; end_reg_a = 5'd2; data_a = 32'h55;
    step();
    wren_a = 1'b1; end_reg_a = 5'd2; data_a = 32'h1;
    wren_b = 1'b1; end_reg_b = 5'd2; data_b = 32'h2;
    end_reg_1 = 5'd2; end_reg_dbg = 5'd2; #1;
`ifdef BANCO_BYPASS_EN
    exp_rd = 32'h2;
`else
    exp_rd = 32'h55;
`endif
    checks++; if (reg_1_out !== exp_rd) begin errors++; $display("FAIL byp_rd got %h want %h", reg_1_out, exp_rd); end
    checks++; if (reg_dbg_out !== 32'h55) begin errors++; $display("FAIL byp_dbg got %h want 55", reg_dbg_out); end
    step();
    checks++; if (reg_1_out !== 32'h2) begin errors++; $display("FAIL byp_next got %h want 2", reg_1_out); end
    reserva = 1'b1; end_reg_r = 5'd11;
    step();
    wren_b = 1'b1; end_reg_b = 5'd11; data_b = 32'h3;
    end_reg_2 = 5'd11; #1;
`ifdef BANCO_BYPASS_EN
    exp_pd = 1'b0;
`else
    exp_pd = 1'b1;
`endif
    checks++; if (pendente_2 !== exp_pd) begin errors++; $display("FAIL byp_pend got %b want %b", pendente_2, exp_pd); end
    step();
    checks++; if (pendente_2 !== 1'b0) begin errors++; $display("FAIL byp_pend_next got %b want 0", pendente_2); end
  endtask

  task automatic test_sweep();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = 16'h0001 << (2 * i);
      if (i % 2 == 0) begin
        wren_a = 1'b1; end_reg_a = 5'(i); data_a = {16'h0, exp};
      end else begin
        wren_b = 1'b1; end_reg_b = 5'(i); data_b = {16'h0, exp};
      end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      exp = 16'h0001 << (2 * i);
      end_reg_1 = 5'(i); end_reg_dbg = 5'(i); #1;
      checks++; if (p_reg_1_out !== exp) begin errors++; $display("FAIL sweep_rd%0d got %h want %h", i, p_reg_1_out, exp); end
      checks++; if (p_reg_dbg_out !== exp) begin errors++; $display("FAIL sweep_dbg%0d got %h want %h", i, p_reg_dbg_out, exp); end
    end
    end_reg_1 = 5'd3;
    reserva = 1'b1; end_reg_r = 5'd3;
    step();
    checks++; if (p_pendente_1 !== 1'b1) begin errors++; $display("FAIL sweep_pend_set got %b want 1", p_pendente_1); end
    wren_b = 1'b1; end_reg_b = 5'd3; data_b = 32'h0000ABCD;
    step();
    checks++; if (p_pendente_1 !== 1'b0) begin errors++; $display("FAIL sweep_pend_clr got %b want 0", p_pendente_1); end
    checks++; if (p_reg_1_out !== 16'hABCD) begin errors++; $display("FAIL sweep_r3 got %h want abcd", p_reg_1_out); end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
